// File: rtl/cla_subtractor_pipe.sv
// Two-stage pipelined carry-lookahead subtractor: diff = a - b - bin, with borrow, overflow and zero flags.
// Result appears 2 edges after acceptance; a stalled output holds the pipe and drops in_ready once stage 1 is full.
module cla_subtractor_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int HALF = WIDTH / 2;
  localparam int NG   = HALF / 4;

  // Returns {carry_out, sum} of x + y + ci; carries are sum-of-products over
  // 4-bit group generate/propagate terms, so nothing ripples between groups.
  function automatic logic [HALF:0] cla_half(input logic [HALF-1:0] x,
                                             input logic [HALF-1:0] y,
                                             input logic            ci);
    logic [HALF-1:0] g, p, c, s;
    logic [NG-1:0]   gg, gp;
    logic [NG:0]     gc;
    logic            t;
    g = x & y;
    p = x ^ y;
    for (int k = 0; k < NG; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    for (int k = 0; k <= NG; k++) begin
      t = ci;
      for (int m = 0; m < k; m++) t = t & gp[m];
      gc[k] = t;
      for (int j = 0; j < k; j++) begin
        t = gg[j];
        for (int m = j + 1; m < k; m++) t = t & gp[m];
        gc[k] = gc[k] | t;
      end
    end
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < 4; i++) begin
        t = gc[k];
        for (int m = 0; m < i; m++) t = t & p[4*k+m];
        c[4*k+i] = t;
        for (int j = 0; j < i; j++) begin
          t = g[4*k+j];
          for (int m = j + 1; m < i; m++) t = t & p[4*k+m];
          c[4*k+i] = c[4*k+i] | t;
        end
      end
    end
    s = p ^ c;
    return {gc[NG], s};
  endfunction

  logic             s1_vld_q;
  logic [HALF-1:0]  s1_dlo_q, s1_dlo_d;
  logic             s1_c_q, s1_c_d;
  logic [HALF-1:0]  s1_ahi_q;
  logic [HALF-1:0]  s1_nbhi_q;
  logic             s1_amsb_q, s1_bmsb_q;

  logic             out_vld_q;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             s2_adv;
  logic             s1_load;
  logic [WIDTH-1:0] nb;
  logic [HALF:0]    lo_res, hi_res;

  assign s2_adv   = !out_vld_q || out_ready;
  assign in_ready = !s1_vld_q || s2_adv;
  assign s1_load  = in_valid && in_ready;

  always_comb begin
    nb       = ~b;
    lo_res   = cla_half(a[HALF-1:0], nb[HALF-1:0], ~bin);
    s1_dlo_d = lo_res[HALF-1:0];
    s1_c_d   = lo_res[HALF];
  end

  always_comb begin
    hi_res = cla_half(s1_ahi_q, s1_nbhi_q, s1_c_q);
    diff_d = {hi_res[HALF-1:0], s1_dlo_q};
    bout_d = ~hi_res[HALF];
    ovf_d  = (s1_amsb_q != s1_bmsb_q) && (diff_d[WIDTH-1] != s1_amsb_q);
    zero_d = ~|diff_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_dlo_q  <= '0;
      s1_c_q    <= 1'b0;
      s1_ahi_q  <= '0;
      s1_nbhi_q <= '0;
      s1_amsb_q <= 1'b0;
      s1_bmsb_q <= 1'b0;
    end else begin
      if (in_ready) s1_vld_q <= in_valid;
      if (s1_load) begin
        s1_dlo_q  <= s1_dlo_d;
        s1_c_q    <= s1_c_d;
        s1_ahi_q  <= a[WIDTH-1:HALF];
        s1_nbhi_q <= nb[WIDTH-1:HALF];
        s1_amsb_q <= a[WIDTH-1];
        s1_bmsb_q <= b[WIDTH-1];
      end
    end
  end

  // Output data only loads when a real operation moves in, so bubbles never disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else if (s2_adv) begin
      out_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        diff_q <= diff_d;
        bout_q <= bout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = out_vld_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// Bench for cla_subtractor_pipe: arithmetic reference model plus scoreboard, directed and random traffic.
module tb_cla_subtractor_pipe;

  typedef struct packed {
    logic [31:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] diff;
  logic        bout, ovf, zero;

  int total = 0;
  int bad = 0;
  res_t exp_q[$];

  cla_subtractor_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic bi);
    res_t r;
    longint sx, sy, sr;
    r.d  = x - y - 32'(bi);
    r.bo = (64'(x) < (64'(y) + 64'(bi)));
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sr = sx - sy - (bi ? 64'sd1 : 64'sd0);
    r.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.z  = (r.d == 32'h0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'h7FFF_FFFF;
      4: v = 32'h0001_0000;
      5: v = 32'h0000_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Scoreboard: log accepted operands, compare every drained result, and verify stalled outputs hold.
  logic        held = 1'b0;
  logic [31:0] h_diff;
  logic        h_bout, h_ovf, h_zero;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      exp_q.delete();
      held = 1'b0;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_diff", diff, 32'h0);
      chk("rst_flags", {bout, ovf, zero}, 3'b000);
      chk("rst_in_ready", in_ready, 1'b1);
    end else begin
      if (held) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", {diff, bout, ovf, zero}, {h_diff, h_bout, h_ovf, h_zero});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", out_valid, 1'b0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("out_diff", diff, e.d);
          chk("out_bout", bout, e.bo);
          chk("out_ovf", ovf, e.ov);
          chk("out_zero", zero, e.z);
        end
      end
      held   = out_valid && !out_ready;
      h_diff = diff;
      h_bout = bout;
      h_ovf  = ovf;
      h_zero = zero;
      if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
    end
  end

  // Entered at a negedge; holds the operands until accepted and returns at the following negedge.
  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic xbin);
    int w;
    w = 0;
    a = xa;
    b = xb;
    bin = xbin;
    in_valid = 1'b1;
    #1;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("send_accept", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [31:0] pa   [11] = '{32'h00000001, 32'h00000001, 32'h00000000, 32'hFFFF0000, 32'h00010000,
                             32'h80000000, 32'h7FFFFFFF, 32'hABCD0004, 32'hFFFF0006, 32'h34980008,
                             32'h00000010};
  logic [31:0] pb   [11] = '{32'h00000001, 32'h00000002, 32'h00000000, 32'h0000FFFF, 32'h00000001,
                             32'h00000001, 32'hFFFFFFFF, 32'hAAAA0004, 32'h12560006, 32'h98760008,
                             32'h00000001};
  logic        pbin [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] pd   [11] = '{32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFE0001, 32'h0000FFFF,
                             32'h7FFFFFFF, 32'h80000000, 32'h01230000, 32'hEDA90000, 32'h9C220000,
                             32'h0000000F};
  logic        pbo  [11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        pov  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion want finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    logic acc;
    int   w;

    for (int i = 0; i < 11; i++) begin
      res_t r;
      r = model(pa[i], pb[i], pbin[i]);
      chk("pin_diff", r.d, pd[i]);
      chk("pin_bout", r.bo, pbo[i]);
      chk("pin_ovf", r.ov, pov[i]);
      chk("pin_zero", r.z, (pd[i] == 32'h0));
    end

    #3;
    chk("init_out_valid", out_valid, 1'b0);
    chk("init_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic case and exact latency.
    out_ready = 1'b1;
    send(pa[0], pb[0], pbin[0]);
    #3 chk("lat1_valid", out_valid, 1'b0);
    @(negedge clk);
    #3;
    chk("lat2_valid", out_valid, 1'b1);
    chk("basic_diff", diff, 32'h0);
    chk("basic_flags", {bout, ovf, zero}, 3'b001);
    @(negedge clk);

    for (int i = 1; i < 7; i++) send(pa[i], pb[i], pbin[i]);
    repeat (4) @(negedge clk);

    // Backpressure: two accepts fill the pipe, the third waits.
    out_ready = 1'b0;
    send(pa[7], pb[7], pbin[7]);
    send(pa[8], pb[8], pbin[8]);
    a = pa[9];
    b = pb[9];
    bin = pbin[9];
    in_valid = 1'b1;
    #1;
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_first_valid", out_valid, 1'b1);
    chk("bp_first_diff", diff, 32'h01230000);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("bp_hold_diff", diff, 32'h01230000);
      chk("bp_hold_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    send(pa[9], pb[9], pbin[9]);
    #3;
    chk("bp_second_diff", diff, 32'hEDA90000);
    chk("bp_second_bout", bout, 1'b0);
    @(negedge clk);
    #3;
    chk("bp_third_valid", out_valid, 1'b1);
    chk("bp_third_diff", diff, 32'h9C220000);
    chk("bp_third_bout", bout, 1'b1);
    repeat (3) @(negedge clk);

    // Asynchronous reset with two operations in flight.
    send(32'h12345678, 32'h00000001, 1'b0);
    send(32'h80000000, 32'h00000001, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_diff", diff, 32'h0);
    chk("arst_flags", {bout, ovf, zero}, 3'b000);
    chk("arst_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #3 chk("post_rst_no_stale", out_valid, 1'b0);
    @(negedge clk);
    send(pa[10], pb[10], pbin[10]);
    #3 chk("post_rst_lat1", out_valid, 1'b0);
    @(negedge clk);
    #3;
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_diff", diff, 32'h0000000F);
    @(negedge clk);

    // Random traffic with random backpressure.
    acc = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = pick();
        b = pick();
        bin = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1 acc = in_valid && in_ready;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 20) begin
      @(negedge clk);
      w++;
    end
    #3 chk("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
